// File: rtl/seq_alu_pkg.sv
// Shared types for the byte-serial ALU: opcodes, FSM states and flag bit positions.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MUL = 4'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_OUT
    } state_e;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;
    localparam int FLG_E = 4;
    localparam int FLG_W = 5;

endpackage

// File: rtl/seq_alu_stream_if.sv
// Streaming port bundle of the byte-serial ALU: beat input, beat output, flags and busy.
interface seq_alu_stream_if
    import seq_alu_pkg::*;
#(
    parameter int BUS_W = 8
) ();

    logic [BUS_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [FLG_W-1:0] flags;
    logic             busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, flags, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, flags, busy
    );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier (low WIDTH bits), built only when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] addend;
    logic [CW-1:0]    step;
    logic             run;

    // The start cycle performs the first partial product and the final one is
    // folded into the product output, so done rises exactly WIDTH cycles after start.
    assign addend  = mplier[0] ? mcand : '0;
    assign done    = run && (step == STEP_LAST);
    assign product = acc + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            step   <= '0;
            run    <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            step   <= CW'(1);
            run    <= 1'b1;
        end else if (run) begin
            if (done) begin
                run <= 1'b0;
            end else begin
                acc    <= acc + addend;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                step   <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu_stream.sv
// Byte-serial ALU: opcode, A and B arrive as beats, result streams back with {E,N,V,C,Z}.
// Opcode 7 (MUL) is only implemented when SEQ_ALU_MUL_EN is defined; otherwise it is illegal.
module seq_alu_stream
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BUS_W = 8
) (
    input logic             clk,
    input logic             rst,
    seq_alu_stream_if.slave bus
);

    localparam int NBEAT = WIDTH / BUS_W;
    localparam int BCW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int SHW   = $clog2(WIDTH);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(NBEAT - 1);

    state_e                 state;
    state_e                 state_d;
    logic [3:0]             op;
    logic [WIDTH-1:0]       a_reg;
    logic [WIDTH-1:0]       b_reg;
    logic [WIDTH-1:0]       res;
    logic [FLG_W-1:0]       flg;
    logic [BCW-1:0]         cnt;
    logic                   in_rdy;
    logic                   out_vld;
    logic                   last_beat;
    logic                   in_fire;
    logic                   out_fire;
    logic                   exec_done;
    logic [WIDTH+FLG_W-1:0] exec_val;

    function automatic logic [WIDTH+FLG_W-1:0] exec_op(
        input logic [3:0]       opc,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] mprod
    );
        logic [WIDTH:0]          wide;
        logic [WIDTH-1:0]        r;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic signed [WIDTH-1:0] sr;
        logic [FLG_W-1:0]        f;
        logic                    legal;
        wide  = '0;
        r     = '0;
        f     = '0;
        legal = 1'b1;
        sa    = signed'(a);
        sb    = signed'(b);
        case (opc)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                r        = wide[WIDTH-1:0];
                f[FLG_C] = wide[WIDTH];
            end
            OP_SUB: begin
                r        = a - b;
                f[FLG_C] = (a < b);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a << b[SHW-1:0];
            OP_SHR: r = a >> b[SHW-1:0];
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: r = mprod;
`endif
            default: legal = 1'b0;
        endcase
        sr = signed'(r);
        if (opc == OP_ADD)
            f[FLG_V] = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        else if (opc == OP_SUB)
            f[FLG_V] = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        if (legal) begin
            f[FLG_Z] = (r == '0);
            f[FLG_N] = r[WIDTH-1];
        end else begin
            r        = '0;
            f        = '0;
            f[FLG_Z] = 1'b1;
            f[FLG_E] = 1'b1;
        end
        return {f, r};
    endfunction

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = out_vld && bus.out_ready;
    assign last_beat = (cnt == BEAT_LAST);

`ifdef SEQ_ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    seq_alu_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_reg),
        .b       (b_reg),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign exec_done = (op == OP_MUL) ? mul_done : 1'b1;
    assign exec_val  = exec_op(op, a_reg, b_reg, mul_prod);

    // Pulse lands in the first EXEC cycle, when both operands are complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mul_start <= 1'b0;
        else
            mul_start <= in_fire && (state == ST_LOAD_B) && last_beat && (op == OP_MUL);
    end
`else
    assign exec_done = 1'b1;
    assign exec_val  = exec_op(op, a_reg, b_reg, '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid)
                    state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                in_rdy = 1'b1;
                if (bus.in_valid && last_beat)
                    state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                in_rdy = 1'b1;
                if (bus.in_valid && last_beat)
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done)
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                out_vld = 1'b1;
                if (bus.out_ready && last_beat)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            flg   <= '0;
            cnt   <= '0;
        end else begin
            if ((in_fire && state != ST_IDLE) || out_fire)
                cnt <= last_beat ? '0 : cnt + 1'b1;
            if (in_fire && state == ST_IDLE)
                op <= bus.in_data[3:0];
            if (in_fire && state == ST_LOAD_A)
                a_reg[cnt*BUS_W +: BUS_W] <= bus.in_data;
            if (in_fire && state == ST_LOAD_B)
                b_reg[cnt*BUS_W +: BUS_W] <= bus.in_data;
            if (state == ST_EXEC && exec_done) begin
                res <= exec_val[WIDTH-1:0];
                flg <= exec_val[WIDTH +: FLG_W];
            end
        end
    end

    // Reset holds in_ready low even though the FSM already sits in IDLE.
    assign bus.in_ready  = in_rdy && !rst;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = res[cnt*BUS_W +: BUS_W];
    assign bus.flags     = flg;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_seq_alu_stream.sv
// Directed bench for seq_alu_stream (WIDTH=16, BUS_W=8); MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seq_alu_stream_if #(.BUS_W(8)) bus ();

    seq_alu_stream #(
        .WIDTH(16),
        .BUS_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input string tag);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b,
                           input string tag);
        send(opb, tag);
        send(a[7:0], tag);
        send(a[15:8], tag);
        send(b[7:0], tag);
        send(b[15:8], tag);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic recv(output logic [15:0] r, output logic [4:0] f);
        int n;
        r = '0;
        f = '0;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (!bus.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            r[i*8 +: 8] = bus.out_data;
            if (i == 0)
                f = bus.flags;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_r, input logic [4:0] exp_f,
                          input int exp_lat, input string tag);
        int          lat;
        logic [15:0] r;
        logic [4:0]  f;
        send_op(opb, a, b, tag);
        wait_out(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        recv(r, f);
        chk({tag, "_result"}, {16'h0, r}, {16'h0, exp_r});
        chk({tag, "_flags"}, {27'h0, f}, {27'h0, exp_f});
        chk({tag, "_idle"}, {29'h0, bus.out_valid, bus.busy, bus.in_ready}, 32'b001);
    endtask

    initial begin
        int          lat;
        logic [15:0] r;
        logic [4:0]  f;

        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'h0, bus.out_data}, 32'd0);
        chk("rst_flags", {27'h0, bus.flags}, 32'd0);
        chk("rst_busy", {31'h0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'h0, bus.in_ready}, 32'd1);

        run_op(8'h00, 16'hFFFF, 16'h0001, 16'h0000, 5'b00011, 2, "add_carry");
        run_op(8'h01, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 2, "sub_ovf");
`ifdef SEQ_ALU_MUL_EN
        run_op(8'h07, 16'h0012, 16'h0034, 16'h03A8, 5'b00000, 17, "mul");
`else
        run_op(8'h07, 16'h0012, 16'h0034, 16'h0000, 5'b10001, 2, "mul_off");
`endif
        run_op(8'h00, 16'h7FFF, 16'h0001, 16'h8000, 5'b01100, 2, "add_ovf");
        run_op(8'h01, 16'h0001, 16'h0002, 16'hFFFF, 5'b01010, 2, "sub_borrow");
        run_op(8'h52, 16'hF0F0, 16'h8F0F, 16'h8000, 5'b01000, 2, "and_hinib");
        run_op(8'h03, 16'h1200, 16'h0034, 16'h1234, 5'b00000, 2, "or");
        run_op(8'hF4, 16'h00FF, 16'h0F0F, 16'h0FF0, 5'b00000, 2, "xor_hinib");
        run_op(8'h06, 16'h8000, 16'h00FF, 16'h0001, 5'b00000, 2, "shr");

        // SHL with a 5-cycle consumer stall on the first result beat
        send(8'h05, "shl");
        send(8'h01, "shl");
        send(8'h00, "shl");
        send(8'h13, "shl");
        bus.out_ready = 1'b0;
        send(8'h00, "shl");
        wait_out(lat);
        chk("shl_latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk("shl_stall_data", {24'h0, bus.out_data}, 32'h08);
            chk("shl_stall_flags", {27'h0, bus.flags}, 32'h0);
            chk("shl_stall_valid", {31'h0, bus.out_valid}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        recv(r, f);
        chk("shl_result", {16'h0, r}, 32'h0008);
        chk("shl_flags", {27'h0, f}, 32'h0);

        run_op(8'h0C, 16'h1234, 16'h5678, 16'h0000, 5'b10001, 2, "illegal");
        run_op(8'h02, 16'h00F0, 16'h0F30, 16'h0030, 5'b00000, 2, "after_illegal");

        // Reset in the middle of loading A
        send(8'h00, "mid");
        send(8'hAA, "mid");
        chk("mid_busy", {31'h0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'h00, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 2, "post_rst_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu_stream.md
Name: seq_alu_stream

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit combinational ALU wrapper.
- Operands of WIDTH bits are streamed in byte-serially over a BUS_W-wide valid/ready port, since pad count is limited.
- The block executes one of eight operations and streams the result back out with status flags.
- It sits directly behind the top-level pin wrapper (ui_in → in_data, uo_out ← out_data).

Parameters:
- WIDTH, 16: operand and result width; must be a multiple of BUS_W and at least BUS_W.
- BUS_W, 8: width of the in/out data buses.
- NBEAT, WIDTH/BUS_W: derived localparam giving beats per operand/result. Not overridable.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  BUS_W  opcode/operand beat.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts beat this cycle.
- out_data  out  BUS_W  result beat.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts beat.
- flags  out  5  {E,N,V,C,Z}; stable while out_valid=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. Reset values: in_ready=0, out_valid=0, out_data=0, flags=0, busy=0. All operand, count and state registers clear, and the FSM enters IDLE.
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. out_data and flags hold stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, OUT.
- IDLE: in_ready=1. An accepted beat latches op=in_data[3:0]; in_data[7:4] is ignored. Next state LOAD_A.
- LOAD_A / LOAD_B: in_ready=1. Each state accepts NBEAT beats, LSB beat first, into A/B. A beat counter wraps to 0 on the last beat, then the FSM advances (LOAD_A→LOAD_B→EXEC).
- EXEC: in_ready=0. Ops 0-6 complete in 1 cycle. MUL completes after WIDTH cycles. On completion, latch the result and flags, then go to OUT.
- OUT: out_valid=1. Emits NBEAT beats, LSB first. After the last accepted beat, out_valid=0 and the FSM returns to IDLE. A new opcode is never accepted in the same cycle as the last output beat.
- Latency: from acceptance of the last B beat, first out_valid=1 occurs 2 cycles later for ops 0-6 and WIDTH+1 cycles later for MUL.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SHL and 6 SHR (logical): shift A by B[$clog2(WIDTH)-1:0].
  - 7 MUL: unsigned; low WIDTH bits of the product.
  - 8-15: illegal. Result=0 and E=1.
- All arithmetic is modulo 2^WIDTH.
- Flags:
  - Z: result==0.
  - C: ADD carry-out; SUB borrow (A<B unsigned); 0 for all other ops.
  - V: signed overflow for ADD/SUB; 0 for all other ops.
  - N: result[WIDTH-1].
  - E: illegal opcode.
  - For an illegal opcode: Z=1, E=1, all other flags 0.
- Gaps in in_valid or out_ready stall the FSM indefinitely without loss of data.
- Reset asserted mid-operation discards all partial operands and results immediately.

Optional Feature:
- Macro: SEQ_ALU_MUL_EN.
- Defined: opcode 7 is the WIDTH-cycle shift-add multiplier, as described above.
- Undefined: no multiplier logic is built. Opcode 7 is treated as illegal (result 0, Z=1, E=1) with 1-cycle EXEC.

Decomposition:
- Package seq_alu_pkg:
  - opcode enum (OP_ADD..OP_MUL);
  - FSM state enum;
  - flag bit index constants (FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3, FLG_E=4).
- Sub-module seq_alu_mul(WIDTH):
  - ports: start, a, b, done, product;
  - iterative shift-add multiplier;
  - instantiated only under SEQ_ALU_MUL_EN.

Test Plan (WIDTH=16, BUS_W=8, out_ready=1 unless stated):
- ADD 0xFFFF+0x0001 → out beats 0x00,0x00; flags Z=1, C=1, V=0, N=0.
- SUB 0x8000-0x0001 → 0xFF,0x7F (0x7FFF); V=1, C=0, N=0.
- MUL 0x0012*0x0034 → 0xA8,0x03 (0x03A8); first out_valid 17 cycles after the last B beat. Without SEQ_ALU_MUL_EN: result 0, E=1.
- SHL A=0x0001, B=0x0013 (shift=3) → 0x0008. Hold out_ready=0 for 5 cycles → out_data=0x08 and flags stable, no beat lost.
- Opcode byte 0x0C, A=0x1234, B=0x5678 → result 0x0000, Z=1, E=1. Block then returns to IDLE and accepts the next op.
- Assert rst after the first A beat → busy=0 and in_ready=0 during reset. After release, a full ADD 0x0002+0x0003 returns 0x0005 with no stale data.
